// File: rtl/config_flit_writer.sv
// Config flit writer: host word writes assemble a flit in a staging register; a write
// to the last word commits it into a FIFO. Optional macro CONFIG_WRITER_STATS_EN adds a sent-flit counter.
module config_flit_writer #(
  parameter int NB_WORDS   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_wr_valid,
  input  logic [$clog2(NB_WORDS)-1:0]   in_wr_addr,
  input  logic [31:0]                   in_wr_data,
  output logic                          in_wr_ready,
  output logic [32*NB_WORDS-1:0]        out_config_data,
  output logic                          out_config_valid,
  input  logic                          out_config_ready,
  output logic [$clog2(FIFO_DEPTH):0]   out_occupancy,
  output logic [31:0]                   out_flits_sent
);

  localparam int AW = $clog2(NB_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = PW + 1;
  localparam int FW = 32 * NB_WORDS;

  typedef logic [FW-1:0] config_flit_t;

  logic [31:0]   stage [NB_WORDS];
  config_flit_t  mem   [FIFO_DEPTH];
  config_flit_t  commit_flit;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occ;
  logic          accept, push, pop;

  assign in_wr_ready      = (occ < OW'(FIFO_DEPTH));
  assign accept           = in_wr_valid && in_wr_ready;
  assign push             = accept && (in_wr_addr == AW'(NB_WORDS - 1));
  assign out_config_valid = (occ != '0);
  assign pop              = out_config_valid && out_config_ready;
  assign out_occupancy    = occ;

  // NOTE: every bit is assigned on every pass through always_comb, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < NB_WORDS; i++) begin
      commit_flit[32*i +: 32] = stage[i];
    end
    commit_flit[FW-1 -: 32] = in_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NB_WORDS; i++) begin
        stage[i] <= '0;
      end
    end else if (accept) begin
      stage[in_wr_addr] <= in_wr_data;
    end
  end

  // NOTE: the FIFO storage is not reset; the output mux masks it while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= commit_flit;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  assign out_config_data = out_config_valid ? mem[rd_ptr] : '0;

`ifdef CONFIG_WRITER_STATS_EN
  logic [31:0] flits_sent;

  always_ff @(posedge clk) begin
    if (rst) begin
      flits_sent <= '0;
    end else if (pop) begin
      flits_sent <= flits_sent + 32'd1;
    end
  end

  assign out_flits_sent = flits_sent;
`else
  assign out_flits_sent = '0;
`endif

endmodule

// File: tb/tb_config_flit_writer.sv
// Scoreboard bench for config_flit_writer: a word-level model queues expected flits,
// a negedge monitor compares handshakes, flags and counters against it.
module tb_config_flit_writer;

  localparam int NB_WORDS   = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = 4;
  localparam int OW         = 3;
  localparam int FW         = 32 * NB_WORDS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_wr_valid = 1'b0;
  logic [AW-1:0] in_wr_addr = '0;
  logic [31:0]   in_wr_data = '0;
  logic          in_wr_ready;
  logic [FW-1:0] out_config_data;
  logic          out_config_valid;
  logic          out_config_ready = 1'b0;
  logic [OW-1:0] out_occupancy;
  logic [31:0]   out_flits_sent;

  config_flit_writer #(.NB_WORDS(NB_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_wr_valid      (in_wr_valid),
    .in_wr_addr       (in_wr_addr),
    .in_wr_data       (in_wr_data),
    .in_wr_ready      (in_wr_ready),
    .out_config_data  (out_config_data),
    .out_config_valid (out_config_valid),
    .out_config_ready (out_config_ready),
    .out_occupancy    (out_occupancy),
    .out_flits_sent   (out_flits_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: host-visible staging words, queue of committed flits, sent count.
  logic [31:0]   m_stage [NB_WORDS];
  logic [FW-1:0] sb [$];
  int            cnt  = 0;
  int unsigned   sent = 0;
  bit            m_pop, m_acc, m_commit;
  logic [FW-1:0] m_flit;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_stage[i]) m_stage[i] = '0;
      sb.delete();
      cnt  = 0;
      sent = 0;
    end else begin
      m_pop    = (cnt > 0) && out_config_ready;
      m_acc    = in_wr_valid && (cnt < FIFO_DEPTH);
      m_commit = 1'b0;
      if (m_acc) begin
        m_stage[in_wr_addr] = in_wr_data;
        if (int'(in_wr_addr) == NB_WORDS - 1) begin
          foreach (m_stage[i]) m_flit[32*i +: 32] = m_stage[i];
          sb.push_back(m_flit);
          m_commit = 1'b1;
        end
      end
      cnt = cnt + int'(m_commit) - int'(m_pop);
      if (m_pop) sent++;
    end
  end

  function automatic logic [31:0] exp_sent();
`ifdef CONFIG_WRITER_STATS_EN
    return sent;
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: compares every cycle, pops the scoreboard on each output handshake.
  always @(negedge clk) begin
    check("wr_ready", FW'(in_wr_ready), FW'(cnt < FIFO_DEPTH));
    check("valid", FW'(out_config_valid), FW'(cnt != 0));
    check("occupancy", FW'(out_occupancy), FW'(cnt));
    check("flits_sent", FW'(out_flits_sent), FW'(exp_sent()));
    if (cnt == 0) begin
      check("idle_data", out_config_data, '0);
    end else if (sb.size() == 0) begin
      check("scoreboard_underrun", FW'(0), FW'(1));
    end else begin
      check("head_data", out_config_data, sb[0]);
      if (out_config_ready) void'(sb.pop_front());
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic r, input logic rs);
    @(posedge clk);
    #1;
    in_wr_valid      = v;
    in_wr_addr       = a;
    in_wr_data       = d;
    out_config_ready = r;
    rst              = rs;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, r, 1'b0);
  endtask

  initial begin
    drive(1'b1, 4'd15, 32'hDEAD, 1'b1, 1'b1);   // writes during reset are ignored
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Full flit with word i == i, drained immediately.
    for (int i = 0; i < NB_WORDS; i++) drive(1'b1, AW'(i), 32'(i), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Partial update then resend.
    drive(1'b1, 4'd2, 32'hAAAA, 1'b1, 1'b0);
    drive(1'b1, 4'd15, 32'hF, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Five commits into a stalled FIFO: the fifth is refused, then drain.
    for (int i = 0; i < 5; i++) drive(1'b1, 4'd15, 32'h100 + 32'(i), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);

    // Occupancy 3 with a same-cycle commit and pop.
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd15, 32'h200 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 4'd15, 32'h2FF, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Reset with two flits queued, then a bare commit.
    for (int i = 0; i < 2; i++) drive(1'b1, 4'd15, 32'h300 + 32'(i), 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    idle(2, 1'b0);
    drive(1'b1, 4'd15, 32'h55, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Randomised traffic with rare resets.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 4'd15 : AW'($urandom_range(0, NB_WORDS - 1)),
            $urandom(),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 99) == 0));
    end
    idle(8, 1'b1);

    // Ten handshakes after a fresh reset.
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 4'd15, 32'h400 + 32'(i), 1'b1, 1'b0);
    idle(4, 1'b1);
    @(negedge clk);
`ifdef CONFIG_WRITER_STATS_EN
    check("ten_handshakes", FW'(out_flits_sent), FW'(10));
`else
    check("ten_handshakes", FW'(out_flits_sent), FW'(0));
`endif
    check("scoreboard_drained", FW'(sb.size()), FW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_flit_writer.md
CONFIG_FLIT_WRITER -- requirements
Module: config_flit_writer

Interface
REQ-001 SHALL have parameter NB_WORDS, default 16; 32-bit words per config flit (flit width 32*NB_WORDS = 512).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; committed flits buffered, power of two, >= 2.
REQ-003 SHALL have port clk, input, 1; single clock for all logic.
REQ-004 SHALL have port rst, input, 1; reset, synchronous and active-high.
REQ-005 SHALL have port in_wr_valid, input, 1; host register-write strobe.
REQ-006 SHALL have port in_wr_addr, input, $clog2(NB_WORDS); word index within the flit.
REQ-007 SHALL have port in_wr_data, input, 32; word value.
REQ-008 SHALL have port in_wr_ready, output, 1; write accepted when high with in_wr_valid.
REQ-009 SHALL have port out_config_data, output, config_flit_t (512); head-of-FIFO flit, word i at bits [32i+31:32i].
REQ-010 SHALL have port out_config_valid, output, 1; flit available.
REQ-011 SHALL have port out_config_ready, input, 1; downstream configurator accepts.
REQ-012 SHALL have port out_occupancy, output, $clog2(FIFO_DEPTH)+1; committed flits not yet sent.
REQ-013 SHALL have port out_flits_sent, output, 32; stats counter (see Configuration).

Function
REQ-014 SHALL hold a NB_WORDS x 32 staging register; an accepted write with in_wr_addr < NB_WORDS-1 updates only that word, with no output effect.
REQ-015 SHALL treat an accepted write to word NB_WORDS-1 as a commit: the staging flit, with that word replaced by in_wr_data, is pushed into the FIFO in the same cycle.
REQ-016 SHALL retain staging contents after a commit; they are not cleared, so the host can resend with partial updates.
REQ-017 SHALL drive in_wr_ready = (occupancy < FIFO_DEPTH), registered-state-derived, independent of in_wr_valid and address; no writes are accepted while full, including non-commit writes.
REQ-018 SHALL make a committed flit visible on out_config_valid/out_config_data the cycle after the commit (latency 1) when the FIFO was empty.
REQ-019 SHALL drive out_config_valid = (occupancy != 0) and out_config_data = the oldest committed flit, stable while valid && !ready.
REQ-020 SHALL pop the head on out_config_valid && out_config_ready; flits leave in commit order; none dropped or duplicated.
REQ-021 SHALL leave occupancy unchanged on a simultaneous push and pop; push-only +1, pop-only -1.
REQ-022 SHALL allow a commit while occupancy == FIFO_DEPTH-1 with a same-cycle pop; occupancy stays FIFO_DEPTH-1.
REQ-023 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-024 SHALL ignore out_config_ready when out_config_valid is low.

Reset
REQ-025 SHALL, in a cycle with rst high, clear staging to 0 and empty the FIFO (occupancy 0, pointers 0); in_wr_valid is ignored that cycle.
REQ-026 SHALL hold outputs during and after reset at in_wr_ready=1, out_config_valid=0, out_config_data=0, out_occupancy=0, out_flits_sent=0.
REQ-027 SHALL, on reset mid-operation, discard queued flits and stage contents; no partial flit is emitted afterwards.

Configuration
REQ-028 SHALL, with CONFIG_WRITER_STATS_EN defined, increment out_flits_sent by 1 on each output handshake, wrapping 0xFFFFFFFF->0, reset to 0.
REQ-029 SHALL, without CONFIG_WRITER_STATS_EN, tie out_flits_sent to 0 and instantiate no counter; all other behaviour is identical.

Verification
REQ-030 SHALL cover: writes words 0..15 with data=i, out_config_ready=1 -> out_config_valid high exactly 1 cycle after the word-15 write, with word i == i.
REQ-031 SHALL cover: after REQ-030, write only word 2=0xAAAA then word 15=0xF -> second flit has word 2=0xAAAA, word 15=0xF, and the other words equal to their first-flit values.
REQ-032 SHALL cover: out_config_ready=0, 5 commits -> the first 4 are accepted, in_wr_ready=0 after the 4th, occupancy=4; raise ready -> 4 flits drain in order and in_wr_ready returns to 1.
REQ-033 SHALL cover: occupancy=3, commit and pop in the same cycle -> occupancy stays 3 and order is preserved.
REQ-034 SHALL cover: rst pulse with 2 flits queued -> out_config_valid=0 the next cycle; a subsequent commit without prior word writes emits words 0..14=0.
REQ-035 SHALL cover: with CONFIG_WRITER_STATS_EN, 10 handshakes -> out_flits_sent=10; without it -> 0.
